// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, frame constants and parity helper used by
//                uart_encoder and uart_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Small synchronous FIFO with registered storage and occupancy
//                count; the head word is visible combinationally on rdata_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [3:0]       count_o
);

    localparam int         c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_DEPTH = 4'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [3:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != c_DEPTH);
    assign do_pop  = pop_i  && (count_q != 4'd0);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_encoder.sv
// ============================================================================
//  Module      : uart_encoder
//  Description : FIFO-buffered UART transmitter, 8N1 framing, LSB first.
//                Define UART_ENCODER_PARITY_EN to add an even parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_encoder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [3:0] fifo_count
);

    localparam logic [7:0] c_BIT_RELOAD = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] c_DEPTH      = 4'(FIFO_DEPTH);

    uart_state_e          state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_ENCODER_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_nonempty;
    logic                 bit_done;

    assign in_ready      = (fifo_count != c_DEPTH);
    assign fifo_nonempty = (fifo_count != 4'd0);
    assign bit_done      = (cnt_q == 8'd0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .wdata_i (in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= '0;
            tx_q    <= STOP_LVL;
`ifdef UART_ENCODER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_ENCODER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        tx_d     = STOP_LVL;
`ifdef UART_ENCODER_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (fifo_nonempty) fifo_pop = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = c_BIT_RELOAD;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = c_BIT_RELOAD;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_ENCODER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef UART_ENCODER_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = c_BIT_RELOAD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (fifo_nonempty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared head-load for both IDLE start and back-to-back STOP->START.
        if (fifo_pop) begin
            shift_d = fifo_head;
            cnt_d   = c_BIT_RELOAD;
            idx_d   = 3'd0;
            state_d = START;
`ifdef UART_ENCODER_PARITY_EN
            par_d   = even_parity(fifo_head);
`endif
        end

        // tx follows the next state so the line changes on the same edge.
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
`ifdef UART_ENCODER_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = STOP_LVL;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || fifo_nonempty;

endmodule

`default_nettype wire
